// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsa_pkg
//  Description : Shared operation codes and state encoding for the
//                digit-serial adder/subtractor/accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsa_pkg;

    // Operation select codes
    localparam logic [1:0] OP_ADD  = 2'b00;   // a + b
    localparam logic [1:0] OP_SUB  = 2'b01;   // a - b
    localparam logic [1:0] OP_ADDC = 2'b10;   // a + b + cin
    localparam logic [1:0] OP_ACC  = 2'b11;   // acc + b

    // Control state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dsa_pkg
`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_adder_if
//  Description : Operand request and result handshake bundle of the
//                digit-serial adder. The adder sits on the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
) ();

    // Request channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Status
    logic             busy;

    // Requester / result consumer side
    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface : digit_serial_adder_if
`default_nettype wire

// File: rtl/digit_serial_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : adder_slice
//  Description : DIGIT-bit combinational ripple-carry adder; the only
//                arithmetic resource of the digit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_slice #(
    parameter int DIGIT = 2
) (
    input  wire logic [DIGIT-1:0] x,
    input  wire logic [DIGIT-1:0] y,
    input  wire logic             ci,
    output logic      [DIGIT-1:0] s,
    output logic                  co
);

    logic ripple;

    // Bit-by-bit ripple: sum bit and carry propagate from bit 0 upward
    always_comb begin
        ripple = ci;
        s      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ ripple;
            ripple = (x[i] & y[i]) | (ripple & (x[i] ^ y[i]));
        end
        co = ripple;
    end

endmodule : adder_slice
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_adder
//  Description : Multi-cycle WIDTH-bit add / subtract / add-with-carry /
//                accumulate unit. Operands are consumed DIGIT bits per clock,
//                least-significant digit first, through one shared slice.
//                WIDTH must be a multiple of DIGIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    digit_serial_adder_if.slave bus
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [WIDTH-1:0] opa_q;        // remaining digits of operand A
    logic [WIDTH-1:0] opb_q;        // remaining digits of (possibly inverted) B
    logic             carry_q;      // carry between digits
    logic             a_msb_q;      // sign of operand A, kept for overflow
    logic             b_msb_q;      // sign of operand B, kept for overflow
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] acc_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Operand capture values
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic             carry_d;

    // Select operands and initial carry from the requested operation
    always_comb begin
        opa_d   = (bus.op == OP_ACC) ? acc_q : bus.a;
        opb_d   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        carry_d = (bus.op == OP_SUB)  ? 1'b1 :
                  (bus.op == OP_ADDC) ? bus.cin : 1'b0;
    end

    // ------------------------------------------------------------------
    // Shared digit adder
    // ------------------------------------------------------------------
    logic [DIGIT-1:0] slice_s;
    logic             slice_co;

    adder_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x  (opa_q[DIGIT-1:0]),
        .y  (opb_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // ------------------------------------------------------------------
    // Digit shifting: operands move down, results enter from the top so
    // that after NDIG steps the result sits fully aligned in sum_q.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_shift_d;
    logic [WIDTH-1:0] opa_shift_d;
    logic [WIDTH-1:0] opb_shift_d;

    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign sum_shift_d = slice_s;
            assign opa_shift_d = '0;
            assign opb_shift_d = '0;
        end else begin : g_multi_digit
            assign sum_shift_d = {slice_s, sum_q[WIDTH-1:DIGIT]};
            assign opa_shift_d = {{DIGIT{1'b0}}, opa_q[WIDTH-1:DIGIT]};
            assign opb_shift_d = {{DIGIT{1'b0}}, opb_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    logic last_digit;
    logic ovf_d;

    assign last_digit = (cnt_q == LAST_CNT);
    // Same-sign operands producing a differently-signed result
    assign ovf_d      = (a_msb_q == b_msb_q) && (slice_s[DIGIT-1] != a_msb_q);

    // Control FSM with registered handshake outputs and datapath update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here
                    if (bus.in_valid) begin
                        opa_q      <= opa_d;
                        opb_q      <= opb_d;
                        a_msb_q    <= opa_d[WIDTH-1];
                        b_msb_q    <= opb_d[WIDTH-1];
                        carry_q    <= carry_d;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    opa_q   <= opa_shift_d;
                    opb_q   <= opb_shift_d;
                    carry_q <= slice_co;
                    sum_q   <= sum_shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= slice_co;
                        ovf_q       <= ovf_d;
                        acc_q       <= sum_shift_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;

endmodule : digit_serial_adder
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_serial_adder
//  Description : Directed bench for the digit-serial adder. Three instances
//                (DIGIT = 2, 8, 1) share the same stimulus; results and
//                latencies are compared against hand-computed values and a
//                small arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;
    import dsa_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       cin;
    logic       out_ready;

    int n_vec;
    int n_err;
    logic [7:0] acc_m;

    digit_serial_adder_if #(.WIDTH(8)) u_if2 ();
    digit_serial_adder_if #(.WIDTH(8)) u_if8 ();
    digit_serial_adder_if #(.WIDTH(8)) u_if1 ();

    assign u_if2.in_valid = in_valid;  assign u_if2.a = a;  assign u_if2.b = b;
    assign u_if2.op = op;  assign u_if2.cin = cin;  assign u_if2.out_ready = out_ready;
    assign u_if8.in_valid = in_valid;  assign u_if8.a = a;  assign u_if8.b = b;
    assign u_if8.op = op;  assign u_if8.cin = cin;  assign u_if8.out_ready = out_ready;
    assign u_if1.in_valid = in_valid;  assign u_if1.a = a;  assign u_if1.b = b;
    assign u_if1.op = op;  assign u_if1.cin = cin;  assign u_if1.out_ready = out_ready;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));
    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8));
    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {cout, ovf, sum}
    function automatic logic [9:0] ref_op(input logic [1:0] o, input logic [7:0] va,
                                          input logic [7:0] vb, input logic vc,
                                          input logic [7:0] accv);
        logic [7:0] x;
        int ux, uy, sx, sy, r, sr;
        logic c, v;
        x  = (o == OP_ACC) ? accv : va;
        ux = int'(x);      uy = int'(vb);
        sx = int'($signed(x));  sy = int'($signed(vb));
        if (o == OP_SUB) begin
            r  = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            r  = ux + uy + ((o == OP_ADDC) ? int'(vc) : 0);
            sr = sx + sy + ((o == OP_ADDC) ? int'(vc) : 0);
            c  = (r > 255);
        end
        v = (sr > 127) || (sr < -128);
        return {c, v, r[7:0]};
    endfunction

    // Issue one operation to all three instances with out_ready held high and
    // check latency, result flags and return to idle for each of them.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] va,
                          input logic [7:0] vb, input logic vc, input logic [7:0] es,
                          input logic ec, input logic eo);
        int lat2, lat8, lat1;
        logic [9:0] r2, r8, r1;
        lat2 = 0; lat8 = 0; lat1 = 0;
        r2 = '0;  r8 = '0;  r1 = '0;
        @(negedge clk);
        op = o; a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, " in_ready"}, {29'd0, u_if2.in_ready, u_if8.in_ready, u_if1.in_ready}, 32'd7);
        @(posedge clk); #1;
        // Operand inputs are scrambled after acceptance; results must not care
        in_valid = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (u_if2.out_valid && lat2 == 0) begin lat2 = k; r2 = {u_if2.cout, u_if2.ovf, u_if2.sum}; end
            if (u_if8.out_valid && lat8 == 0) begin lat8 = k; r8 = {u_if8.cout, u_if8.ovf, u_if8.sum}; end
            if (u_if1.out_valid && lat1 == 0) begin lat1 = k; r1 = {u_if1.cout, u_if1.ovf, u_if1.sum}; end
        end
        chk({tag, " lat D2"}, lat2, 32'd4);
        chk({tag, " lat D8"}, lat8, 32'd1);
        chk({tag, " lat D1"}, lat1, 32'd8);
        chk({tag, " res D2"}, {22'd0, r2}, {22'd0, ec, eo, es});
        chk({tag, " res D8"}, {22'd0, r8}, {22'd0, ec, eo, es});
        chk({tag, " res D1"}, {22'd0, r1}, {22'd0, ec, eo, es});
        chk({tag, " idle"}, {26'd0, u_if2.in_ready, u_if8.in_ready, u_if1.in_ready,
                             u_if2.busy, u_if8.busy, u_if1.busy}, 32'h38);
    endtask

    initial begin
        logic [7:0]  held;
        logic [9:0]  m;
        logic [1:0]  ro;
        logic [7:0]  ra, rb;
        logic        rc;
        n_vec = 0; n_err = 0; acc_m = 8'h00;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; cin = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset D2", {20'd0, u_if2.in_ready, u_if2.out_valid, u_if2.busy, u_if2.cout,
                         u_if2.ovf, 3'd0, u_if2.sum}, {20'd0, 5'b10000, 3'd0, 8'h00});
        chk("reset D1", {23'd0, u_if1.in_ready, u_if1.out_valid, u_if1.busy, u_if1.sum}, {23'd0, 3'b100, 8'h00});
        @(negedge clk) rst_n = 1'b1;

        // Basic arithmetic
        run_op("add",    OP_ADD,  8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op("sub1",   OP_SUB,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_op("sub2",   OP_SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_op("addc",   OP_ADDC, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("acc7f",  OP_ACC,  8'hAA, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("acc01",  OP_ACC,  8'h55, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Backpressure in DONE
        @(negedge clk);
        op = OP_ADD; a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp enter done", {31'd0, u_if2.out_valid}, 32'd1);
        held = u_if2.sum;
        chk("bp sum", {24'd0, held}, {24'd0, 8'h8D});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0); a = 8'($urandom); b = 8'($urandom); op = OP_ACC;
            @(posedge clk); #1;
            chk("bp hold", {22'd0, u_if2.out_valid, u_if2.in_ready, u_if2.sum},
                           {22'd0, 1'b1, 1'b0, 8'h8D});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release", {29'd0, u_if2.in_ready, u_if2.out_valid, u_if2.busy}, 32'd4);
        chk("bp release D1/D8", {28'd0, u_if8.in_ready, u_if1.in_ready, u_if8.out_valid, u_if1.out_valid}, 32'hC);

        // Asynchronous reset two cycles into RUN
        @(negedge clk);
        op = OP_ADD; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst D2", {20'd0, u_if2.in_ready, u_if2.out_valid, u_if2.busy, u_if2.cout,
                        u_if2.ovf, 3'd0, u_if2.sum}, {20'd0, 5'b10000, 3'd0, 8'h00});
        chk("arst D1", {29'd0, u_if1.in_ready, u_if1.busy, u_if1.out_valid}, 32'd4);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("arst released", {31'd0, u_if2.in_ready}, 32'd1);
        run_op("acc after rst", OP_ACC, 8'hEE, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0);
        acc_m = 8'h05;

        // Mixed operations against the reference model
        for (int n = 0; n < 10; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m  = ref_op(ro, ra, rb, rc, acc_m);
            run_op("model", ro, ra, rb, rc, m[7:0], m[9], m[8]);
            acc_m = m[7:0];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_digit_serial_adder
`default_nettype wire
